data_memory_block: RTL and testbench

- Block-granular main data memory and responder for the data cache's miss/write-back port.
- Accepts one 128-bit block read or write per request and holds MEM_BUSYWAIT high for a fixed access latency.
- Completes the access and drops MEM_BUSYWAIT for exactly one cycle.
- Sits between the data cache and the testbench/top level; it is the only backing store for data accesses.

---
 rtl/data_memory_block_pkg.sv | 17 +
 rtl/data_memory_block_array.sv | 38 +++
 rtl/data_memory_block.sv | 112 +++++++++++
 tb/tb_data_memory_block.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_block_pkg.sv
// Shared constants and state encoding for the block-granular data memory
// and the data cache timing logic that depends on its latency.
package dmem_pkg;

  localparam int BLOCK_W      = 128;
  localparam int WORD_W       = 32;
  localparam int BLOCK_ADDR_W = 28;
  localparam int DEPTH_LOG2   = 8;
  localparam int LATENCY      = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/data_memory_block_array.sv
// Single-port synchronous block RAM with write-enable and a registered read port.
// The read register only changes on an enabled read, so it holds the last block read.
module data_mem_array
  import dmem_pkg::*;
#(
  parameter int BLOCK_W    = dmem_pkg::BLOCK_W,
  parameter int DEPTH_LOG2 = dmem_pkg::DEPTH_LOG2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  i_wrEn,
  input  logic                  i_rdEn,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [BLOCK_W-1:0]    i_wdata,
  output logic [BLOCK_W-1:0]    o_rdata
);

  logic [BLOCK_W-1:0] r_mem [0:(2**DEPTH_LOG2)-1];
  logic [BLOCK_W-1:0] r_rdata;

  // Storage is deliberately left out of reset so contents survive a RESET.
  always_ff @(posedge CLK) begin
    if (i_wrEn) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_rdata <= '0;
    end else if (i_rdEn) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_memory_block.sv
// Fixed-latency block memory responder for the data cache miss/write-back port.
// IDLE accepts a request, BUSY counts down the latency, DONE drops busy for one cycle.
module data_memory_block
  import dmem_pkg::*;
#(
  parameter int BLOCK_W    = dmem_pkg::BLOCK_W,
  parameter int DEPTH_LOG2 = dmem_pkg::DEPTH_LOG2,
  parameter int LATENCY    = dmem_pkg::LATENCY
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    MEM_READ,
  input  logic                    MEM_WRITE,
  input  logic [BLOCK_ADDR_W-1:0] MEM_BLOCK_ADDR,
  input  logic [BLOCK_W-1:0]      MEM_WRITE_DATA,
  output logic [BLOCK_W-1:0]      MEM_READ_DATA,
  output logic                    MEM_BUSYWAIT
);

  localparam int               CNT_W     = $clog2(LATENCY);
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_BUSY = BUSY;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]            r_state;
  logic [CNT_W-1:0]      r_counter;
  logic                  r_isWrite;
  logic [DEPTH_LOG2-1:0] r_addr;
  logic [BLOCK_W-1:0]    r_wdata;

  logic w_request;
  logic w_accept;
  logic w_accessNow;
  logic w_wrEn;
  logic w_rdEn;
  logic w_unusedAddrHigh;

  assign w_request = MEM_READ | MEM_WRITE;
  assign w_accept  = (r_state == S_IDLE) && w_request && !RESET;

  // Read+write together resolves to a write, which leaves MEM_READ_DATA alone.
  assign w_accessNow = (r_state == S_BUSY) && (r_counter == CNT_LAST) && !RESET;
  assign w_wrEn      = w_accessNow & r_isWrite;
  assign w_rdEn      = w_accessNow & ~r_isWrite;

  assign w_unusedAddrHigh = ^MEM_BLOCK_ADDR[BLOCK_ADDR_W-1:DEPTH_LOG2];

  always_comb begin
    MEM_BUSYWAIT = 1'b0;
    case (r_state)
      S_IDLE:  MEM_BUSYWAIT = w_request;
      S_BUSY:  MEM_BUSYWAIT = 1'b1;
      S_DONE:  MEM_BUSYWAIT = 1'b0;
      default: MEM_BUSYWAIT = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_counter <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_request) begin
            r_state   <= S_BUSY;
            r_counter <= CNT_START;
          end
        end
        S_BUSY: begin
          r_counter <= r_counter - CNT_W'(1);
          if (r_counter == CNT_LAST) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state   <= S_IDLE;
          r_counter <= '0;
        end
      endcase
    end
  end

  // Request fields are captured once so the requester may change inputs while BUSY.
  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_isWrite <= MEM_WRITE;
      r_addr    <= MEM_BLOCK_ADDR[DEPTH_LOG2-1:0];
      r_wdata   <= MEM_WRITE_DATA;
    end
  end

  data_mem_array #(
    .BLOCK_W   (BLOCK_W),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .CLK    (CLK),
    .RESET  (RESET),
    .i_wrEn (w_wrEn),
    .i_rdEn (w_rdEn),
    .i_addr (r_addr),
    .i_wdata(r_wdata),
    .o_rdata(MEM_READ_DATA)
  );

endmodule

// File: tb/tb_data_memory_block.sv
// Self-checking bench for data_memory_block: table of block transactions with a
// read-data scoreboard, plus hand sequences for mid-access, reset and held requests.
module tb_data_memory_block;
  import dmem_pkg::*;

  localparam int BOUND = 20;
  localparam int NVEC  = 10;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         MEM_READ;
  logic         MEM_WRITE;
  logic [27:0]  MEM_BLOCK_ADDR;
  logic [127:0] MEM_WRITE_DATA;
  logic [127:0] MEM_READ_DATA;
  logic         MEM_BUSYWAIT;

  int total = 0;
  int bad   = 0;

  logic [127:0] sbQ[$];
  logic [127:0] lastRead;

  typedef struct {
    logic         rd;
    logic         wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
    logic [127:0] expRd;
  } vec_t;

  vec_t vecs[NVEC];

  data_memory_block dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_BLOCK_ADDR(MEM_BLOCK_ADDR),
    .MEM_WRITE_DATA(MEM_WRITE_DATA),
    .MEM_READ_DATA (MEM_READ_DATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Returns the number of busy cycles seen before MEM_BUSYWAIT went low.
  task automatic waitDone(input string name, output int lat);
    lat = 0;
    forever begin
      @(negedge CLK);
      if (MEM_BUSYWAIT === 1'b0) break;
      lat++;
      if (lat > BOUND) begin
        total++;
        bad++;
        $display("[TB] FAIL %s timeout: busy still high after %0d cycles, required low", name, lat);
        break;
      end
    end
  endtask

  task automatic finishAccess(input string name, input logic isRead);
    logic [127:0] exp;
    if (isRead) begin
      exp = (sbQ.size() > 0) ? sbQ.pop_front() : '0;
      checkOutput({name, " rdata"}, MEM_READ_DATA, exp);
      lastRead = exp;
    end else begin
      checkOutput({name, " rdata held"}, MEM_READ_DATA, lastRead);
    end
  endtask

  task automatic applyStimulus(input string name, input logic rd, input logic wr,
                               input logic [27:0] addr, input logic [127:0] wdata,
                               input logic [127:0] expRd, input bit hold);
    int lat;
    @(posedge CLK);
    #1;
    MEM_READ       = rd;
    MEM_WRITE      = wr;
    MEM_BLOCK_ADDR = addr;
    MEM_WRITE_DATA = wdata;
    if (rd && !wr) sbQ.push_back(expRd);
    waitDone(name, lat);
    checkOutput({name, " latency"}, 128'(lat), 128'(LATENCY));
    finishAccess(name, rd && !wr);
    if (!hold) begin
      @(posedge CLK);
      #1;
      MEM_READ  = 1'b0;
      MEM_WRITE = 1'b0;
    end
  endtask

  localparam logic [127:0] D1    = 128'h44443333_22221111_DEADBEEF_00000001;
  localparam logic [127:0] DA5   = {16{8'hA5}};
  localparam logic [127:0] D7    = 128'h77777777_66666666_55555555_44444444;
  localparam logic [127:0] D9    = 128'h0BADF00D_CAFEBABE_12345678_9ABCDEF0;
  localparam logic [127:0] DFF   = 128'hF0F0F0F0_0F0F0F0F_13572468_ACE0BDF1;
  localparam logic [127:0] DONES = {128{1'b1}};
  localparam logic [127:0] D5    = 128'h55AA55AA_01234567_89ABCDEF_FEDCBA98;

  initial begin
    int lat;
    vecs[0] = '{rd: 1'b0, wr: 1'b1, addr: 28'h0000003, wdata: D1,  expRd: '0};
    vecs[1] = '{rd: 1'b1, wr: 1'b0, addr: 28'h0000003, wdata: '0,  expRd: D1};
    vecs[2] = '{rd: 1'b0, wr: 1'b1, addr: 28'h0000103, wdata: DA5, expRd: '0};
    vecs[3] = '{rd: 1'b1, wr: 1'b0, addr: 28'h0000003, wdata: '0,  expRd: DA5};
    vecs[4] = '{rd: 1'b0, wr: 1'b1, addr: 28'h0000007, wdata: D7,  expRd: '0};
    vecs[5] = '{rd: 1'b1, wr: 1'b0, addr: 28'h0000007, wdata: '0,  expRd: D7};
    vecs[6] = '{rd: 1'b0, wr: 1'b1, addr: 28'h0000009, wdata: D9,  expRd: '0};
    vecs[7] = '{rd: 1'b1, wr: 1'b0, addr: 28'hFFFFF09, wdata: '0,  expRd: D9};
    vecs[8] = '{rd: 1'b0, wr: 1'b1, addr: 28'h00000FF, wdata: DFF, expRd: '0};
    vecs[9] = '{rd: 1'b1, wr: 1'b0, addr: 28'h00001FF, wdata: '0,  expRd: DFF};

    RESET          = 1'b1;
    MEM_READ       = 1'b0;
    MEM_WRITE      = 1'b0;
    MEM_BLOCK_ADDR = '0;
    MEM_WRITE_DATA = '0;
    lastRead       = '0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checkOutput("idle busy", 128'(MEM_BUSYWAIT), 128'(0));
      checkOutput("idle rdata", MEM_READ_DATA, '0);
    end

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr,
                    vecs[i].wdata, vecs[i].expRd, 1'b0);
    end

    // Read of 0x3 whose inputs change to addr 0x7 with MEM_READ dropped in cycle 2.
    @(posedge CLK);
    #1;
    MEM_READ       = 1'b1;
    MEM_WRITE      = 1'b0;
    MEM_BLOCK_ADDR = 28'h3;
    sbQ.push_back(DA5);
    @(negedge CLK);
    checkOutput("mid busy c0", 128'(MEM_BUSYWAIT), 128'(1));
    @(negedge CLK);
    checkOutput("mid busy c1", 128'(MEM_BUSYWAIT), 128'(1));
    @(posedge CLK);
    #1;
    MEM_BLOCK_ADDR = 28'h7;
    MEM_READ       = 1'b0;
    waitDone("mid", lat);
    checkOutput("mid latency", 128'(lat), 128'(LATENCY - 2));
    finishAccess("mid", 1'b1);

    // Write of all-ones to 0x9 aborted by RESET in cycle 3.
    @(posedge CLK);
    #1;
    MEM_WRITE      = 1'b1;
    MEM_READ       = 1'b0;
    MEM_BLOCK_ADDR = 28'h9;
    MEM_WRITE_DATA = DONES;
    repeat (3) @(negedge CLK);
    @(posedge CLK);
    #1;
    RESET     = 1'b1;
    MEM_WRITE = 1'b0;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    checkOutput("abort busy", 128'(MEM_BUSYWAIT), 128'(0));
    checkOutput("abort rdata", MEM_READ_DATA, '0);
    lastRead = '0;
    applyStimulus("read after abort", 1'b1, 1'b0, 28'h9, '0, D9, 1'b0);

    applyStimulus("rw both", 1'b1, 1'b1, 28'h5, D5, '0, 1'b0);
    applyStimulus("read 5", 1'b1, 1'b0, 28'h5, '0, D5, 1'b0);

    // Request held through DONE starts a second access the following cycle.
    applyStimulus("hold first", 1'b1, 1'b0, 28'h3, '0, DA5, 1'b1);
    sbQ.push_back(DA5);
    waitDone("hold second", lat);
    checkOutput("hold second latency", 128'(lat), 128'(LATENCY));
    finishAccess("hold second", 1'b1);
    @(posedge CLK);
    #1;
    MEM_READ = 1'b0;
    @(negedge CLK);
    checkOutput("final idle busy", 128'(MEM_BUSYWAIT), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
